// File: rtl/cpu_icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding
// and request tag width.
package cpu_icache_direct_pkg;

    localparam int TAG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_icache_direct_if.sv
// Memory-side read bus of the instruction cache.
// Handshake: o_bus_request rises with o_bus_address and both hold steady until
// the rising edge that samples i_bus_ready high; i_bus_rdata is valid in that
// same cycle. i_bus_ready while no request is outstanding is ignored.
interface cpu_icache_direct_if;

    logic        o_bus_request;
    logic [31:0] o_bus_address;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;

    modport master (
        output o_bus_request,
        output o_bus_address,
        input  i_bus_rdata,
        input  i_bus_ready
    );

    modport slave (
        input  o_bus_request,
        input  o_bus_address,
        output i_bus_rdata,
        output i_bus_ready
    );

endinterface

// File: rtl/cpu_icache_ram.sv
// Single-port synchronous data+tag store for the cache; one-cycle read,
// read-before-write. Contents are never reset.
module cpu_icache_ram #(
    parameter int LINES = 256,
    parameter int IW    = $clog2(LINES),
    parameter int TW    = 30 - IW
) (
    input  logic          i_clock,
    input  logic [IW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   wdata,
    input  logic [TW-1:0] wtag,
    output logic [31:0]   rdata,
    output logic [TW-1:0] rtag
);

    logic [31:0]   mem_data [LINES];
    logic [TW-1:0] mem_tag  [LINES];

    always_ff @(posedge i_clock) begin
        if (we) begin
            mem_data[addr] <= wdata;
            mem_tag[addr]  <= wtag;
        end
        rdata <= mem_data[addr];
        rtag  <= mem_tag[addr];
    end

endmodule

// File: rtl/cpu_icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache. A new request is any
// change of i_input_tag; the answer is reported by echoing that tag.
module cpu_icache_direct
    import cpu_icache_direct_pkg::*;
#(
    parameter int LINES = 256
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [TAG_W-1:0]        i_input_tag,
    input  logic [31:0]             i_address,
    input  logic                    i_invalidate,
    output logic [TAG_W-1:0]        o_output_tag,
    output logic [31:0]             o_rdata,
    cpu_icache_direct_if.master     bus,
    output state_t                  state_dbg
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    state_t             state;
    state_t             state_nx;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   last_tag;
    logic [TAG_W-1:0]   lat_tag;
    logic [29:0]        lat_waddr;
    logic               inv_pend;
    logic               bus_req_q;
    logic [31:0]        bus_addr_q;

    logic [IW-1:0]      lat_idx;
    logic [TW-1:0]      lat_ctag;
    logic [IW-1:0]      ram_addr;
    logic               ram_we;
    logic [31:0]        ram_rdata;
    logic [TW-1:0]      ram_rtag;
    logic               new_req;
    logic               hit;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^i_address[1:0];

    assign lat_idx  = lat_waddr[IW-1:0];
    assign lat_ctag = lat_waddr[29:IW];
    assign new_req  = (i_input_tag != last_tag);
    // An invalidate landing on the lookup edge forces a miss.
    assign hit      = valid[lat_idx] && (ram_rtag == lat_ctag) && !i_invalidate;
    assign ram_we   = (state == ST_FILL) && bus.i_bus_ready;
    // The read is launched from IDLE so its data is ready during LOOKUP.
    assign ram_addr = (state == ST_FILL) ? lat_idx : i_address[IW+1:2];

    assign bus.o_bus_request = bus_req_q;
    assign bus.o_bus_address = bus_addr_q;
    assign state_dbg         = state;

    cpu_icache_ram #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_ram (
        .i_clock (i_clock),
        .addr    (ram_addr),
        .we      (ram_we),
        .wdata   (bus.i_bus_rdata),
        .wtag    (lat_ctag),
        .rdata   (ram_rdata),
        .rtag    (ram_rtag)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (new_req) state_nx = ST_LOOKUP;
            ST_LOOKUP: state_nx = hit ? ST_IDLE : ST_FILL;
            ST_FILL:   if (bus.i_bus_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid        <= '0;
            last_tag     <= '0;
            lat_tag      <= '0;
            lat_waddr    <= '0;
            inv_pend     <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            o_output_tag <= '0;
            o_rdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_req) begin
                        lat_tag   <= i_input_tag;
                        lat_waddr <= i_address[31:2];
                        last_tag  <= i_input_tag;
                    end
                    if (i_invalidate) valid <= '0;
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        o_rdata      <= ram_rdata;
                        o_output_tag <= lat_tag;
                    end else begin
                        bus_req_q  <= 1'b1;
                        bus_addr_q <= {lat_waddr, 2'b00};
                    end
                    if (i_invalidate) valid <= '0;
                end
                ST_FILL: begin
                    if (i_invalidate) inv_pend <= 1'b1;
                    if (bus.i_bus_ready) begin
                        o_rdata      <= bus.i_bus_rdata;
                        o_output_tag <= lat_tag;
                        bus_req_q    <= 1'b0;
                        inv_pend     <= 1'b0;
                        // A flush seen during the fill also drops the line being filled.
                        if (inv_pend || i_invalidate) valid          <= '0;
                        else                          valid[lat_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cpu_icache_direct.md
CPU_ICACHE_DIRECT -- requirements
Module: cpu_icache_direct

Interface
REQ-001 SHALL have parameter LINES, default 256, number of one-word cache lines (power of two, >=2).
REQ-002 SHALL have port i_clock  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset i_reset, synchronous, active-high; clock i_clock.
REQ-004 SHALL have port i_input_tag  input  8  request tag; any change from last accepted tag is a new request.
REQ-005 SHALL have port i_address  input  32  fetch address, sampled when a request is accepted.
REQ-006 SHALL have port i_invalidate  input  1  single-cycle pulse; invalidate all lines.
REQ-007 SHALL have port o_output_tag  output  8  tag of last completed request.
REQ-008 SHALL have port o_rdata  output  32  instruction word for o_output_tag.
REQ-009 SHALL have port o_bus_request  output  1  memory read request, held until ready.
REQ-010 SHALL have port o_bus_address  output  32  word-aligned read address.
REQ-011 SHALL have port i_bus_rdata  input  32  memory read data, valid with i_bus_ready.
REQ-012 SHALL have port i_bus_ready  input  1  memory read completion, sampled on rising edge.

Function
REQ-013 Address split SHALL be index = i_address[log2(LINES)+1:2], tag = i_address[31:log2(LINES)+2], bits [1:0] ignored.
REQ-014 States SHALL be IDLE, LOOKUP, FILL; reset state IDLE.
REQ-015 IDLE: if i_input_tag != last accepted tag -> latch tag and address, update last accepted tag, issue RAM read, go LOOKUP.
REQ-016 LOOKUP: valid[index] and stored tag match (hit) -> o_rdata <= RAM data, o_output_tag <= latched tag, go IDLE.
REQ-017 Hit latency: o_output_tag SHALL equal the new tag exactly 2 cycles after the edge that samples the changed i_input_tag.
REQ-018 LOOKUP miss -> o_bus_request <= 1, o_bus_address <= {latched address[31:2], 2'b00}, go FILL.
REQ-019 FILL: on i_bus_ready -> write RAM data/tag, set valid[index], o_rdata <= i_bus_rdata, o_output_tag <= latched tag, o_bus_request <= 0, go IDLE.
REQ-020 o_bus_request and o_bus_address SHALL stay stable from assertion until the edge sampling i_bus_ready.
REQ-021 Tag changes while in LOOKUP/FILL SHALL NOT abort the request; the in-flight request completes with its own tag, the newer tag is accepted on return to IDLE.
REQ-022 Tag comparison SHALL be pure 8-bit inequality; wrap 255 -> 0 is a new request.
REQ-023 i_invalidate in IDLE/LOOKUP SHALL clear all valid bits on that edge; a LOOKUP on that edge SHALL be treated as miss.
REQ-024 i_invalidate during FILL SHALL set a pending flag; completion still returns bus data, line SHALL NOT be marked valid, all valid bits cleared, flag cleared.
REQ-025 i_bus_ready outside FILL SHALL be ignored.

Reset
REQ-026 On i_reset: state IDLE, valid bits all 0, last accepted tag 0, o_output_tag 0, o_rdata 0, o_bus_request 0, o_bus_address 0, pending invalidate 0.
REQ-027 Reset mid-FILL SHALL drop the request next cycle; late i_bus_ready SHALL be ignored; after reset any i_input_tag != 0 is a new request.
REQ-028 RAM contents SHALL NOT require reset.

Structure
REQ-029 Shared package SHALL hold state encoding and tag width (8).
REQ-030 Data+tag storage SHALL be sub-module cpu_icache_ram: single-port synchronous RAM, 1-cycle read; valid bits SHALL be flops in cpu_icache_direct.

Verification
REQ-031 Cold miss: tag 0->1, address 0x100, ready 3 cycles later with 0x00000013 -> one bus request to 0x100, o_output_tag=1, o_rdata=0x00000013.
REQ-032 Hit: tag 1->2, address 0x100 again -> no bus request, o_output_tag=2 after 2 cycles, o_rdata=0x00000013.
REQ-033 Conflict: LINES=256, addresses 0x100 then 0x500 -> both miss, second evicts first; re-fetch 0x100 misses.
REQ-034 Invalidate during FILL of 0x200: data returned with correct tag; following fetch of 0x200 misses.
REQ-035 Tag 255->0 and tag change mid-FILL: each tag answered once, in order, with correct data.
REQ-036 Reset during FILL: o_bus_request=0 next cycle, o_output_tag=0; late i_bus_ready causes no output change.
